svc_axil_master: RTL

- Single-outstanding AXI-Lite initiator. Converts a simple valid/ready command stream (read or write, one beat) into AXI-Lite AW/W/B or AR/R transactions.
- Returns each result on a valid/ready response stream.
- Sits between control logic (sequencers, debug bridges, CPU shims) and AXI-Lite responders such as svc_axil_regfile.

---
 rtl/svc_axil_pkg.sv | 19 +
 rtl/svc_axil_master.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/svc_axil_pkg.sv
// svc_axil_pkg: shared FSM state encoding and AXI response codes for svc_axil_master
package svc_axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_B,
        ST_RD_A,
        ST_RD_D,
        ST_RSP,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/svc_axil_master.sv
// svc_axil_master: single-outstanding AXI-Lite initiator driven by a valid/ready command stream
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_*                     one-beat read/write command (valid/ready)
//   rsp_*                     result stream (valid/ready): rdata (0 for writes), resp, write echo
//   m_axil_aw*/w*/b*/ar*/r*   AXI-Lite initiator channels
//   timeout_sticky            (SVC_AXIL_MASTER_TIMEOUT_EN only) set on first timeout, cleared by reset
//
// Build option: define SVC_AXIL_MASTER_TIMEOUT_EN to add the response timeout, the DRAIN state
// and the timeout_sticky output. Without it the block waits indefinitely for the responder.
module svc_axil_master
    import svc_axil_pkg::*;
#(
    parameter int AXIL_ADDR_WIDTH = 16,
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [AXIL_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AXIL_DATA_WIDTH-1:0] cmd_wdata,
    input  logic [AXIL_STRB_WIDTH-1:0] cmd_wstrb,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [AXIL_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                 rsp_resp,
    output logic                       rsp_write,
`ifdef SVC_AXIL_MASTER_TIMEOUT_EN
    output logic                       timeout_sticky,
`endif
    output logic [AXIL_ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic                       m_axil_awvalid,
    input  logic                       m_axil_awready,
    output logic [AXIL_DATA_WIDTH-1:0] m_axil_wdata,
    output logic [AXIL_STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                       m_axil_wvalid,
    input  logic                       m_axil_wready,
    input  logic                       m_axil_bvalid,
    input  logic [1:0]                 m_axil_bresp,
    output logic                       m_axil_bready,
    output logic [AXIL_ADDR_WIDTH-1:0] m_axil_araddr,
    output logic                       m_axil_arvalid,
    input  logic                       m_axil_arready,
    input  logic                       m_axil_rvalid,
    input  logic [AXIL_DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]                 m_axil_rresp,
    output logic                       m_axil_rready
);

    state_t                     r_state;
    logic                       r_cmd_ready;
    logic                       r_rsp_valid;
    logic [AXIL_DATA_WIDTH-1:0] r_rsp_rdata;
    logic [1:0]                 r_rsp_resp;
    logic                       r_rsp_write;
    logic [AXIL_ADDR_WIDTH-1:0] r_awaddr;
    logic                       r_awvalid;
    logic [AXIL_DATA_WIDTH-1:0] r_wdata;
    logic [AXIL_STRB_WIDTH-1:0] r_wstrb;
    logic                       r_wvalid;
    logic                       r_bready;
    logic [AXIL_ADDR_WIDTH-1:0] r_araddr;
    logic                       r_arvalid;
    logic                       r_rready;

    // A channel counts as done when it is idle or handshaking on this edge
    logic w_aw_done;
    logic w_w_done;

    assign w_aw_done = !r_awvalid || m_axil_awready;
    assign w_w_done  = !r_wvalid || m_axil_wready;

`ifdef SVC_AXIL_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_timed_out;
    logic          r_tmo_sticky;
    logic          w_busy;
    logic          w_fin;
    logic          w_drain_done;

    assign w_busy = (r_state == ST_WR) || (r_state == ST_WR_B) || (r_state == ST_RD_A) || (r_state == ST_RD_D);
    // A B/R handshake on the timeout edge wins over the timeout
    assign w_fin  = (r_state == ST_WR_B && m_axil_bvalid) || (r_state == ST_RD_D && m_axil_rvalid);
    // DRAIN ends once every pending request and the late response have handshaked
    assign w_drain_done = w_aw_done && w_w_done && (!r_arvalid || m_axil_arready) &&
                          (!r_bready || m_axil_bvalid) && (!r_rready || m_axil_rvalid);
    assign timeout_sticky = r_tmo_sticky;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= RESP_OKAY;
            r_rsp_write <= 1'b0;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
`ifdef SVC_AXIL_MASTER_TIMEOUT_EN
            r_tmo_cnt    <= '0;
            r_timed_out  <= 1'b0;
            r_tmo_sticky <= 1'b0;
`endif
        end else begin
            // Request valids drop only after their own handshake, whatever the state
            if (r_awvalid && m_axil_awready) r_awvalid <= 1'b0;
            if (r_wvalid && m_axil_wready) r_wvalid <= 1'b0;
            if (r_arvalid && m_axil_arready) r_arvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_rsp_write <= cmd_write;
                        r_rsp_rdata <= '0;
                        r_rsp_resp  <= RESP_OKAY;
`ifdef SVC_AXIL_MASTER_TIMEOUT_EN
                        r_timed_out <= 1'b0;
`endif
                        if (cmd_write) begin
                            r_awaddr  <= cmd_addr;
                            r_wdata   <= cmd_wdata;
                            r_wstrb   <= cmd_wstrb;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WR;
                        end else begin
                            r_araddr  <= cmd_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD_A;
                        end
                    end
                end
                ST_WR: begin
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (m_axil_bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= m_axil_bresp;
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RD_A: begin
                    if (m_axil_arready) begin
                        r_rready <= 1'b1;
                        r_state  <= ST_RD_D;
                    end
                end
                ST_RD_D: begin
                    if (m_axil_rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_rdata <= m_axil_rdata;
                        r_rsp_resp  <= m_axil_rresp;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
`ifdef SVC_AXIL_MASTER_TIMEOUT_EN
                        if (r_timed_out) begin
                            // Accept and discard whatever the responder still owes us
                            r_bready <= r_rsp_write;
                            r_rready <= !r_rsp_write;
                            r_state  <= ST_DRAIN;
                        end else begin
                            r_cmd_ready <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
`else
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
`endif
                    end
                end
`ifdef SVC_AXIL_MASTER_TIMEOUT_EN
                ST_DRAIN: begin
                    if (r_bready && m_axil_bvalid) r_bready <= 1'b0;
                    if (r_rready && m_axil_rvalid) r_rready <= 1'b0;
                    if (w_drain_done) begin
                        r_bready    <= 1'b0;
                        r_rready    <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
`ifdef SVC_AXIL_MASTER_TIMEOUT_EN
            if (r_state == ST_IDLE) begin
                r_tmo_cnt <= '0;
            end else if (w_busy) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
                if (r_tmo_cnt == TMO_LAST && !w_fin) begin
                    // Overrides the case above; pending request valids stay up for DRAIN
                    r_bready     <= 1'b0;
                    r_rready     <= 1'b0;
                    r_rsp_resp   <= RESP_DECERR;
                    r_rsp_rdata  <= '0;
                    r_rsp_valid  <= 1'b1;
                    r_timed_out  <= 1'b1;
                    r_tmo_sticky <= 1'b1;
                    r_state      <= ST_RSP;
                end
            end
`endif
        end
    end

    assign cmd_ready      = r_cmd_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_resp       = r_rsp_resp;
    assign rsp_write      = r_rsp_write;
    assign m_axil_awaddr  = r_awaddr;
    assign m_axil_awvalid = r_awvalid;
    assign m_axil_wdata   = r_wdata;
    assign m_axil_wstrb   = r_wstrb;
    assign m_axil_wvalid  = r_wvalid;
    assign m_axil_bready  = r_bready;
    assign m_axil_araddr  = r_araddr;
    assign m_axil_arvalid = r_arvalid;
    assign m_axil_rready  = r_rready;

endmodule
